// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU controller: opcode constants, controller state
// encodings, and small helpers used by the controller's next-state and
// output decoding.
// -----------------------------------------------------------------------------
package cpu_pkg;

   // Instruction-register opcodes
   typedef enum logic [2:0] {
      OP_HLT = 3'b000,
      OP_SKZ = 3'b001,
      OP_ADD = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100,
      OP_LDA = 3'b101,
      OP_STO = 3'b110,
      OP_JMP = 3'b111
   } opcode_e;

   // Controller states: IDLE waits for the first fetch edge, S0..S7 are the
   // eight phases of one instruction, HALT is sticky until reset.
   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_S0   = 4'd1,
      ST_S1   = 4'd2,
      ST_S2   = 4'd3,
      ST_S3   = 4'd4,
      ST_S4   = 4'd5,
      ST_S5   = 4'd6,
      ST_S6   = 4'd7,
      ST_S7   = 4'd8,
      ST_HALT = 4'd9
   } state_e;

   // Control outputs bundled so the decoder can default them in one line
   typedef struct packed {
      logic rd;
      logic wr;
      logic load_ir;
      logic inc_pc;
      logic load_pc;
      logic load_acc;
      logic datactl_ena;
      logic halt;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

   // Opcodes that read an operand from memory into the accumulator path
   function automatic logic is_alu(input opcode_e op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

   // Free-running phase sequence S0 -> S1 -> ... -> S7 -> S0
   function automatic state_e next_phase(input state_e s);
      state_e n;
      case (s)
         ST_S0:   n = ST_S1;
         ST_S1:   n = ST_S2;
         ST_S2:   n = ST_S3;
         ST_S3:   n = ST_S4;
         ST_S4:   n = ST_S5;
         ST_S5:   n = ST_S6;
         ST_S6:   n = ST_S7;
         default: n = ST_S0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// Rising-edge detector for the fetch strobe.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   din      in   level to watch
//   rise     out  high while din=1 and the registered copy of din is 0
// -----------------------------------------------------------------------------
module edge_det (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic rise
);

   logic din_q;
   logic armed_q;

   // armed_q stays low for the first clock after reset release so that a
   // level already high when reset goes away is captured into din_q without
   // ever being reported as an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         din_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         din_q   <= din;
         armed_q <= 1'b1;
      end
   end

   assign rise = armed_q & din & ~din_q;

endmodule

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
// Eight-phase instruction sequencer for a simple accumulator CPU. Phases are
// aligned to the rising edge of the fetch strobe; an edge arriving early
// re-aligns the sequencer to S0 and reports sync_err for one cycle.
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   fetch        in   fetch strobe, high 4 of every 8 cycles
//   opcode[2:0]  in   instruction opcode, valid from S2 onward
//   zero         in   accumulator-is-zero flag, sampled leaving S3
//   rd           out  memory read enable
//   wr           out  memory write strobe
//   load_ir      out  instruction-register load
//   inc_pc       out  program-counter increment
//   load_pc      out  program-counter load (jump)
//   load_acc     out  accumulator load
//   datactl_ena  out  data-bus driver enable
//   halt         out  CPU halted
//   sync_err     out  one-cycle pulse on an out-of-phase fetch edge
// -----------------------------------------------------------------------------
module cpu_controller
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       fetch,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       rd,
   output logic       wr,
   output logic       load_ir,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_acc,
   output logic       datactl_ena,
   output logic       halt,
   output logic       sync_err
);

   state_e  state_q, state_d;
   logic    zero_q;
   logic    sync_err_q, sync_err_d;
   logic    fetch_rise;
   opcode_e op;
   ctrl_t   ctrl;

   assign op = opcode_e'(opcode);

   edge_det u_fetch_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (fetch),
      .rise    (fetch_rise)
   );

   // State register, zero flag capture and sync error flop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         zero_q     <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_err_q <= sync_err_d;
         // Every exit from S3 samples the flag; SKZ only ever looks at zero_q
         if (state_q == ST_S3) begin
            zero_q <= zero;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      sync_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fetch_rise) begin
               state_d = ST_S0;
            end
         end
         // A fetch edge in S7 is the expected one and just wraps to S0
         ST_S7:   state_d = ST_S0;
         ST_HALT: state_d = ST_HALT;
         default: begin
            // S0..S6: an edge here means the strobe and sequencer disagree;
            // re-align rather than finish the instruction.
            if (fetch_rise) begin
               state_d    = ST_S0;
               sync_err_d = 1'b1;
            end else if ((state_q == ST_S3) && (op == OP_HLT)) begin
               state_d = ST_HALT;
            end else begin
               state_d = next_phase(state_q);
            end
         end
      endcase
   end

   // Output decode
   always_comb begin
      ctrl = CTRL_NONE;
      case (state_q)
         ST_S0, ST_S1: begin
            ctrl.rd      = 1'b1;
            ctrl.load_ir = 1'b1;
            ctrl.inc_pc  = 1'b1;
         end
         ST_S3: begin
            ctrl.halt = (op == OP_HLT);
         end
         ST_S4: begin
            ctrl.rd          = is_alu(op);
            ctrl.datactl_ena = (op == OP_STO);
            ctrl.load_pc     = (op == OP_JMP);
            ctrl.inc_pc      = (op == OP_SKZ) && zero_q;
         end
         ST_S5: begin
            ctrl.rd          = is_alu(op);
            ctrl.load_acc    = is_alu(op);
            ctrl.datactl_ena = (op == OP_STO);
            // wr only coincides with the bus driver being enabled
            ctrl.wr          = (op == OP_STO);
            ctrl.load_pc     = (op == OP_JMP);
         end
         ST_S6: begin
            ctrl.datactl_ena = (op == OP_STO);
            ctrl.inc_pc      = (op == OP_SKZ) && zero_q;
         end
         ST_HALT: begin
            ctrl.halt = 1'b1;
         end
         default: ctrl = CTRL_NONE;
      endcase
   end

   assign rd          = ctrl.rd;
   assign wr          = ctrl.wr;
   assign load_ir     = ctrl.load_ir;
   assign inc_pc      = ctrl.inc_pc;
   assign load_pc     = ctrl.load_pc;
   assign load_acc    = ctrl.load_acc;
   assign datactl_ena = ctrl.datactl_ena;
   assign halt        = ctrl.halt;
   assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
// Directed stimulus for cpu_controller with literal per-phase expectations
// plus a behavioural phase model checked every cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_cpu_controller;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       fetch = 1'b0;
   logic [2:0] opcode = 3'b000;
   logic       zero = 1'b0;
   logic       rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt, sync_err;

   logic [8:0] dut_v;
   logic [2:0] cur_op = 3'b000;
   int         total = 0;
   int         bad   = 0;

   // Output vector order: rd wr load_ir inc_pc load_pc load_acc datactl_ena halt sync_err
   localparam logic [8:0] V_NONE  = 9'b000000000;
   localparam logic [8:0] V_FETCH = 9'b101100000;
   localparam logic [8:0] V_RD    = 9'b100000000;
   localparam logic [8:0] V_RDACC = 9'b100001000;
   localparam logic [8:0] V_DC    = 9'b000000100;
   localparam logic [8:0] V_WRDC  = 9'b010000100;
   localparam logic [8:0] V_INC   = 9'b000100000;
   localparam logic [8:0] V_LPC   = 9'b000010000;
   localparam logic [8:0] V_HALT  = 9'b000000010;
   localparam logic [8:0] V_SYNC  = 9'b000000001;

   cpu_controller dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fetch       (fetch),
      .opcode      (opcode),
      .zero        (zero),
      .rd          (rd),
      .wr          (wr),
      .load_ir     (load_ir),
      .inc_pc      (inc_pc),
      .load_pc     (load_pc),
      .load_acc    (load_acc),
      .datactl_ena (datactl_ena),
      .halt        (halt),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   assign dut_v = {rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt, sync_err};

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: -1 = waiting for first edge, 0..7 = instruction phase, 8 = halted
   function automatic logic [8:0] model_out(input int ph, input logic [2:0] op,
                                           input logic zq, input logic se);
      logic alu;
      logic [8:0] v;
      alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
      v = V_NONE;
      if (ph == 8)                 v = V_HALT;
      else if (ph == 0 || ph == 1) v = V_FETCH;
      else if (ph == 3 && op == 3'd0) v = V_HALT;
      else if (ph == 4) begin
         if (alu)          v = V_RD;
         if (op == 3'd6)   v = V_DC;
         if (op == 3'd7)   v = V_LPC;
         if (op == 3'd1 && zq) v = V_INC;
      end else if (ph == 5) begin
         if (alu)          v = V_RDACC;
         if (op == 3'd6)   v = V_WRDC;
         if (op == 3'd7)   v = V_LPC;
      end else if (ph == 6) begin
         if (op == 3'd6)   v = V_DC;
         if (op == 3'd1 && zq) v = V_INC;
      end
      v[0] = se;
      return v;
   endfunction

   initial begin : model_proc
      int   ph;
      logic zq, se, prev_f, rise, se_n;
      int   clocks;
      ph = -1; zq = 1'b0; se = 1'b0; prev_f = 1'b0; clocks = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            ph = -1; zq = 1'b0; se = 1'b0; prev_f = 1'b0; clocks = 0;
            check("model_reset", dut_v, V_NONE);
         end else begin
            check("model", dut_v, model_out(ph, opcode, zq, se));
            // inputs stay stable until after the next rising edge
            rise = fetch && !prev_f && (clocks > 0);
            se_n = rise && (ph >= 0) && (ph <= 6);
            if (ph == 3) zq = zero;
            if (ph == 8) ph = 8;
            else if (ph == -1) begin
               if (rise) ph = 0;
            end else if (rise && ph <= 6) ph = 0;
            else if (ph == 3 && opcode == 3'd0) ph = 8;
            else ph = (ph + 1) % 8;
            se = se_n;
            prev_f = fetch;
            clocks++;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input logic f, input logic z, input logic [8:0] exp, input string name);
      @(posedge clk);
      #1;
      fetch  = f;
      zero   = z;
      opcode = cur_op;
      @(negedge clk);
      check(name, dut_v, exp);
   endtask

   task automatic startup();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, V_NONE, "idle_low");
      step(1'b1, 1'b0, V_NONE, "idle_rise");
   endtask

   task automatic instr(input string name, input logic [2:0] op, input logic z3, input logic z4,
                        input logic [8:0] e4, input logic [8:0] e5, input logic [8:0] e6,
                        input logic s0sync);
      cur_op = op;
      step(1'b1, 1'b0, s0sync ? (V_FETCH | V_SYNC) : V_FETCH, {name, "_S0"});
      step(1'b1, 1'b0, V_FETCH, {name, "_S1"});
      step(1'b1, 1'b0, V_NONE,  {name, "_S2"});
      step(1'b0, z3,   V_NONE,  {name, "_S3"});
      step(1'b0, z4,   e4,      {name, "_S4"});
      step(1'b0, 1'b0, e5,      {name, "_S5"});
      step(1'b0, 1'b0, e6,      {name, "_S6"});
      step(1'b1, 1'b0, V_NONE,  {name, "_S7"});
      $display("instr %s op=%0d z3=%0b z4=%0b t=%0t", name, op, z3, z4, $time);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", dut_v, V_NONE);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);

      // first edge from IDLE, then ten back-to-back instructions
      startup();
      instr("add1", 3'd2, 1'b0, 1'b0, V_RD,   V_RDACC, V_NONE, 1'b0);
      instr("sto1", 3'd6, 1'b0, 1'b0, V_DC,   V_WRDC,  V_DC,   1'b0);
      instr("skz1", 3'd1, 1'b1, 1'b0, V_INC,  V_NONE,  V_INC,  1'b0);
      instr("skz0", 3'd1, 1'b0, 1'b1, V_NONE, V_NONE,  V_NONE, 1'b0);
      instr("jmp",  3'd7, 1'b0, 1'b0, V_LPC,  V_LPC,   V_NONE, 1'b0);
      instr("lda",  3'd5, 1'b1, 1'b1, V_RD,   V_RDACC, V_NONE, 1'b0);
      instr("and",  3'd3, 1'b0, 1'b0, V_RD,   V_RDACC, V_NONE, 1'b0);
      instr("xor",  3'd4, 1'b1, 1'b0, V_RD,   V_RDACC, V_NONE, 1'b0);
      instr("add2", 3'd2, 1'b0, 1'b0, V_RD,   V_RDACC, V_NONE, 1'b0);
      instr("sto2", 3'd6, 1'b1, 1'b1, V_DC,   V_WRDC,  V_DC,   1'b0);

      // early fetch edge in S4 forces S0 with a one-cycle sync_err
      cur_op = 3'd2;
      step(1'b1, 1'b0, V_FETCH, "sync_S0");
      step(1'b1, 1'b0, V_FETCH, "sync_S1");
      step(1'b1, 1'b0, V_NONE,  "sync_S2");
      step(1'b0, 1'b0, V_NONE,  "sync_S3");
      step(1'b1, 1'b0, V_RD,    "sync_S4_rise");
      instr("resync", 3'd6, 1'b0, 1'b0, V_DC, V_WRDC, V_DC, 1'b1);

      // reset in the middle of a STO write drops wr/datactl_ena immediately
      cur_op = 3'd6;
      step(1'b1, 1'b0, V_FETCH, "rst_S0");
      step(1'b1, 1'b0, V_FETCH, "rst_S1");
      step(1'b1, 1'b0, V_NONE,  "rst_S2");
      step(1'b0, 1'b0, V_NONE,  "rst_S3");
      step(1'b0, 1'b0, V_DC,    "rst_S4");
      step(1'b0, 1'b0, V_WRDC,  "rst_S5");
      #1 reset_n = 1'b0;
      #1 check("rst_async_wr_dc", {7'b0, wr, datactl_ena}, 9'b0);
      check("rst_async_all", dut_v, V_NONE);
      $display("reset mid-S5 t=%0t", $time);
      fetch = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      // fetch already high at release must not start an instruction
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, V_NONE, "rel_fetch_high");
      startup();
      instr("post_rst", 3'd7, 1'b0, 1'b0, V_LPC, V_LPC, V_NONE, 1'b0);

      // HLT: halt from S3, sticky through 20 fetch edges, cleared by reset
      cur_op = 3'd0;
      step(1'b1, 1'b0, V_FETCH, "hlt_S0");
      step(1'b1, 1'b0, V_FETCH, "hlt_S1");
      step(1'b1, 1'b0, V_NONE,  "hlt_S2");
      step(1'b0, 1'b0, V_HALT,  "hlt_S3");
      for (int c = 0; c < 160; c++) begin
         cur_op = 3'($urandom_range(7, 0));
         step((((c + 1) % 8) >= 4) ? 1'b1 : 1'b0, c[0], V_HALT, "halted");
      end
      $display("halted through 20 fetch edges t=%0t", $time);
      @(posedge clk); #1 reset_n = 1'b0;
      #1 check("halt_reset", dut_v, V_NONE);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as listed below.
REQ-002 clk  input  1  system clock; all state advances on the rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 fetch  input  1  instruction-fetch strobe from the clock generator, high 4 of every 8 cycles.
REQ-005 opcode  input  3  instruction-register opcode, valid from S2 onward.
REQ-006 zero  input  1  accumulator-is-zero flag.
REQ-007 rd  output  1  memory read enable.
REQ-008 wr  output  1  memory write strobe.
REQ-009 load_ir  output  1  instruction-register load.
REQ-010 inc_pc  output  1  program-counter increment.
REQ-011 load_pc  output  1  program-counter load (jump).
REQ-012 load_acc  output  1  accumulator load.
REQ-013 datactl_ena  output  1  data-bus driver enable.
REQ-014 halt  output  1  CPU halted.
REQ-015 sync_err  output  1  one-cycle pulse when a fetch rising edge arrives out of phase.

Function
REQ-016 The state machine SHALL have the states IDLE, S0..S7 and HALT.
REQ-017 Rising-edge detect: a fetch rising edge is fetch=1 while the registered copy of fetch = 0.
REQ-018 IDLE SHALL stay in IDLE until a fetch rising edge, then go to S0 on the next clock.
REQ-019 S0->S1->...->S7->S0 SHALL advance one state per clock, free-running.
REQ-020 A fetch rising edge seen in S0..S6 SHALL force the next state to S0 and pulse sync_err for exactly one cycle; a rising edge in S7 or IDLE SHALL NOT pulse sync_err.
REQ-021 Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111; ALU class = ADD, AND, XOR, LDA.
REQ-022 zero SHALL be captured into zero_q on the clock that leaves S3; SKZ decisions SHALL use zero_q only.
REQ-023 Outputs SHALL be combinational from the state register, opcode and zero_q; all outputs not listed for a state are 0.
REQ-024 S0 and S1: rd, load_ir and inc_pc = 1 (two-byte fetch).
REQ-025 S2: all outputs 0.
REQ-026 S3 with HLT: halt = 1, next state HALT; S3 with any other opcode: all outputs 0.
REQ-027 S4: ALU class -> rd; STO -> datactl_ena; JMP -> load_pc; SKZ -> inc_pc = zero_q.
REQ-028 S5: ALU class -> rd and load_acc; STO -> datactl_ena and wr; JMP -> load_pc.
REQ-029 S6: STO -> datactl_ena; SKZ -> inc_pc = zero_q.
REQ-030 S7: all outputs 0.
REQ-031 HALT: halt = 1 and all other outputs 0; fetch edges SHALL be ignored, sync_err SHALL stay 0, and HALT SHALL be left only through reset.
REQ-032 wr SHALL never be 1 unless datactl_ena is also 1 in the same cycle.

Reset
REQ-033 reset_n low SHALL immediately force state = IDLE, zero_q = 0, fetch_q = 0 and sync_err = 0; every output SHALL read 0 while reset is active.
REQ-034 Reset asserted mid-instruction (including during a STO write in S5) SHALL drop wr and datactl_ena without waiting for a clock.
REQ-035 After reset release, the block SHALL wait in IDLE for a fresh fetch rising edge; a fetch already high at release is not an edge.

Structure
REQ-036 Opcode constants and state encodings SHALL live in the shared package cpu_pkg.
REQ-037 The fetch rising-edge detector SHALL be a single sub-module, edge_det (ports clk, reset_n, din, rise).
REQ-038 The state register, zero_q and the sync_err flop SHALL be the only sequential elements in cpu_controller.

Verification
REQ-039 Reset release, then fetch pattern 0000_1111 repeating -> S0 entered the cycle after the first rise; rd, load_ir and inc_pc high for 2 cycles; no sync_err over 10 instructions.
REQ-040 opcode=ADD -> rd high in S4 and S5, load_acc high only in S5; opcode=STO -> datactl_ena high S4-S6, wr high only in S5.
REQ-041 opcode=SKZ with zero=1 at S3 and zero=0 at S4 -> inc_pc high in S4 and S6; repeat with zero=0 at S3 -> inc_pc never high in S4-S6.
REQ-042 opcode=HLT -> halt high from S3 onward; 20 further fetch edges produce no other output activity; reset_n low clears halt.
REQ-043 Inject a fetch rise in S4 -> next state S0 and sync_err = 1 for exactly 1 cycle.
REQ-044 Drop reset_n mid-S5 of a STO -> wr and datactl_ena go to 0 asynchronously.
